gbuff_sram_be: RTL
==================

Name: gbuff_sram_be

Overview:
- Parametrised successor to the single-port global-buffer SRAM in the systolic testbench.
- Adds independent read and write ports, per-byte write enables, a registered read with a valid strobe, and write-first collision forwarding.
- Adds a sequential clear engine that zeroes one entry per cycle, replacing the single-cycle whole-array reset.
- Sits between the DMA/loader (write side) and the systolic array feeders (read side).

Parameters:
- DATA_W, 128, word width in bits; must be a multiple of 8.
- DEPTH, 256, number of words; need not be a power of two.
- ADDR_W, 8, address width; must satisfy 2**ADDR_W >= DEPTH.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- clr_req  in  1  single-cycle request to start a soft clear.
- busy  out  1  high while the clear engine runs.
- wr_en  in  1  write request.
- wr_addr  in  ADDR_W  write address.
- wr_be  in  DATA_W/8  byte enables; bit i selects wr_data[8i+7:8i].
- wr_data  in  DATA_W  write data.
- rd_en  in  1  read request.
- rd_addr  in  ADDR_W  read address.
- rd_data  out  DATA_W  registered read data.
- rd_valid  out  1  rd_data updated this cycle.
- rd_perr  out  1  parity error flag; see Optional Feature.

Behaviour:
- Reset (rst=1 at an edge): FSM goes to CLEAR, clr_ptr=0, rd_data=0, rd_valid=0, rd_perr=0. busy is 1 from the first edge after rst deasserts.
- FSM states are CLEAR and IDLE.
- In CLEAR:
  - Each cycle writes 0 to mem[clr_ptr], then clr_ptr increments.
  - When clr_ptr==DEPTH-1 is written, the FSM goes to IDLE and busy falls.
  - A clear therefore takes exactly DEPTH cycles.
  - wr_en and rd_en are ignored and rd_valid=0.
  - clr_req is ignored; a clear in progress does not restart.
  - rst mid-clear restarts the clear from clr_ptr=0.
- In IDLE: clr_req=1 enters CLEAR at the next edge. A write accepted in the same cycle is still performed and is then overwritten by the clear.
- Write (IDLE, wr_en=1): at the edge, only the bytes with wr_be set are updated. wr_be=0 makes the write a no-op.
- Read (IDLE, rd_en=1):
  - rd_data <= mem[rd_addr] at the edge, so latency is 1 cycle.
  - rd_valid=1 for that cycle only.
  - When no read is accepted, rd_data holds its last value and rd_valid=0.
- Collision (rd_en and wr_en both set, rd_addr==wr_addr): write-first, per byte.
  - Bytes with wr_be set return wr_data.
  - All other bytes return the old stored bytes.
- Out-of-range address (>= DEPTH):
  - Writes are dropped.
  - Reads return rd_data=0 with rd_valid=1.
- Back-to-back reads and writes are accepted every cycle in IDLE; there is no throttling.

Optional Feature:
- Macro: GBUFF_SRAM_PARITY_EN.
- With the macro defined:
  - Each byte stores an extra even-parity bit, written on every byte write and as 0 during clear.
  - On a read, rd_perr=1 alongside rd_valid if any byte's recomputed parity differs from its stored bit.
  - Forwarded collision bytes never flag an error.
  - A testbench-only hierarchical force on a stored parity bit is the injection mechanism.
- Without the macro: no parity storage is built, and rd_perr is tied 0.

Test Plan:
- Reset and clear, DEPTH=256: hold rst 2 cycles, release -> busy=1 for exactly 256 cycles. Then read addresses 0, 128 and 255 -> rd_data=0, rd_valid=1, one cycle after each rd_en.
- Byte-enable write: write addr 5 data all-0xAA with be=all-ones, then data all-0x55 with be=16'h00FF -> read addr 5 returns 0xAA in the upper 8 bytes and 0x55 in the lower 8 bytes.
- Collision forwarding: mem[9]=all-0x11; same cycle write addr 9 data all-0x22 be=16'h000F and read addr 9 -> rd_data = 0x11 upper 12 bytes, 0x22 lower 4 bytes.
- Soft clear mid-traffic:
  - Fill addr 0..3 with non-zero data, then pulse clr_req.
  - Pulse clr_req again 10 cycles later -> busy high 256 cycles, not restarted.
  - Reads issued during busy -> rd_valid=0.
  - After the clear, addr 0..3 read 0.
- Reset mid-clear plus out-of-range address, DEPTH=200: assert rst at clear cycle 50 -> clear restarts and takes 200 cycles. Then write addr 220 and read addr 220 -> read returns 0, rd_valid=1, and mem 0..199 is unchanged.
- Parity (with GBUFF_SRAM_PARITY_EN): write addr 3, force byte 0's parity bit flipped, read addr 3 -> rd_perr=1 with rd_valid. Without the macro -> rd_perr=0.

Source files
------------

// File: rtl/gbuff_sram_be.sv
// Global-buffer SRAM: independent read/write ports, byte enables, write-first forwarding and a
// sequential clear engine. Define GBUFF_SRAM_PARITY_EN to store and check per-byte even parity.
module gbuff_sram_be #(
    parameter int unsigned DATA_W = 128,
    parameter int unsigned DEPTH  = 256,
    parameter int unsigned ADDR_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr_req,
    output logic                  busy,
    input  logic                  wr_en,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [DATA_W/8-1:0]   wr_be,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_W-1:0]     rd_addr,
    output logic [DATA_W-1:0]     rd_data,
    output logic                  rd_valid,
    output logic                  rd_perr
);

    localparam int unsigned NB = DATA_W / 8;

    localparam logic [0:0] StClear = 1'b0;
    localparam logic [0:0] StIdle  = 1'b1;

    logic [0:0]        state_q;
    logic [ADDR_W-1:0] clr_ptr_q;
    logic [DATA_W-1:0] rd_data_q;
    logic              rd_valid_q;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              idle;
    logic              clr_last;
    logic              wr_in_range;
    logic              rd_in_range;
    logic              wr_ok;
    logic [NB-1:0]     fwd;
    logic [DATA_W-1:0] rd_word;

    assign idle        = (state_q == StIdle);
    assign clr_last    = (32'(clr_ptr_q) == DEPTH - 1);
    assign wr_in_range = (32'(wr_addr) < DEPTH);
    assign rd_in_range = (32'(rd_addr) < DEPTH);
    assign wr_ok       = idle && wr_en && wr_in_range;
    // Bytes of the current read that must come from the concurrent write.
    assign fwd         = (wr_ok && (rd_addr == wr_addr)) ? wr_be : '0;

    always_comb begin
        rd_word = '0;
        if (rd_in_range) begin
            for (int i = 0; i < NB; i++) begin
                rd_word[8*i +: 8] = fwd[i] ? wr_data[8*i +: 8] : mem[rd_addr][8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StClear;
            clr_ptr_q  <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else if (state_q == StClear) begin
            rd_valid_q <= 1'b0;
            if (clr_last) begin
                state_q   <= StIdle;
                clr_ptr_q <= '0;
            end else begin
                clr_ptr_q <= clr_ptr_q + 1'b1;
            end
        end else begin
            rd_valid_q <= rd_en;
            if (rd_en) begin
                rd_data_q <= rd_word;
            end
            if (clr_req) begin
                state_q <= StClear;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_q == StClear) begin
                mem[clr_ptr_q] <= '0;
            end else if (wr_ok) begin
                for (int i = 0; i < NB; i++) begin
                    if (wr_be[i]) begin
                        mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
                    end
                end
            end
        end
    end

`ifdef GBUFF_SRAM_PARITY_EN
    logic [NB-1:0] par_q [DEPTH];
    logic [NB-1:0] par_bad;
    logic          rd_perr_q;

    always_comb begin
        par_bad = '0;
        if (rd_in_range) begin
            for (int i = 0; i < NB; i++) begin
                par_bad[i] = !fwd[i] && ((^mem[rd_addr][8*i +: 8]) != par_q[rd_addr][i]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_q == StClear) begin
                par_q[clr_ptr_q] <= '0;
            end else if (wr_ok) begin
                for (int i = 0; i < NB; i++) begin
                    if (wr_be[i]) begin
                        par_q[wr_addr][i] <= ^wr_data[8*i +: 8];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_perr_q <= 1'b0;
        end else if (idle && rd_en) begin
            rd_perr_q <= |par_bad;
        end else begin
            rd_perr_q <= 1'b0;
        end
    end

    assign rd_perr = rd_perr_q;
`else
    assign rd_perr = 1'b0;
`endif

    assign busy     = (state_q == StClear);
    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;

endmodule
